dm_dump_reader: RTL and testbench

Debug reader for the data-memory inspection port. It sweeps the DM debug address (`ram_addr`) across a programmed word range and captures each returned `memory` word. Each word goes out on a valid/ready stream toward the display or a serial link, and a running checksum and word count accumulate over the sweep. It is the consuming end of the port the pipeline writes through `DM`, and runs in the `clk_sys` domain beside the pipeline.

---
 rtl/dm_dbg_pkg.sv | 15 +
 rtl/dm_dump_reader.sv | 126 ++++++++++++
 tb/tb_dm_dump_reader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_dbg_pkg.sv
// Shared definitions for the data-memory debug port: word geometry and reader states.
package dm_dbg_pkg;

   localparam int DM_ADDR_W = 6;
   localparam int DM_DATA_W = 32;
   localparam int DM_LAT_W  = 2;   // read latencies 0..3

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_OUT,
      ST_DONE
   } dm_rd_state_e;

endpackage

// File: rtl/dm_dump_reader.sv
// Sweeps the DM debug address over a word range and streams each word out with
// a running checksum and word count.
module dm_dump_reader
   import dm_dbg_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] memory,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum,
   output logic [ADDR_W:0]   word_cnt
);

   localparam logic [DM_LAT_W-1:0] LAT_LOAD = DM_LAT_W'(RD_LAT);

   dm_rd_state_e        state_q,    state_d;
   logic [DM_LAT_W-1:0] lat_q,      lat_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [ADDR_W-1:0]   last_q,     last_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [DATA_W-1:0]   sum_q,      sum_d;
   logic [ADDR_W:0]     cnt_q,      cnt_d;

   always_comb begin
      // NOTE: every next-state signal defaults to its register first, so no path leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      lat_d      = lat_q;
      ram_addr_d = ram_addr_q;
      last_d     = last_q;
      out_data_d = out_data_q;
      out_addr_d = out_addr_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;

      // An abort wins over everything else, including a handshake in the same cycle.
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  last_d     = last_addr;
                  ram_addr_d = first_addr;
                  lat_d      = LAT_LOAD;
                  sum_d      = '0;
                  cnt_d      = '0;
                  state_d    = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (lat_q != '0) begin
                  lat_d = lat_q - DM_LAT_W'(1);
               end else begin
                  out_data_d = memory;
                  out_addr_d = ram_addr_q;
                  state_d    = ST_OUT;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  sum_d = sum_q + out_data_q;
                  cnt_d = cnt_q + (ADDR_W+1)'(1);
                  if (out_addr_q == last_q) begin
                     state_d = ST_DONE;
                  end else begin
                     ram_addr_d = ram_addr_q + ADDR_W'(1);
                     lat_d      = LAT_LOAD;
                     state_d    = ST_ISSUE;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         lat_q      <= '0;
         ram_addr_q <= '0;
         last_q     <= '0;
         out_data_q <= '0;
         out_addr_q <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q    <= state_d;
         lat_q      <= lat_d;
         ram_addr_q <= ram_addr_d;
         last_q     <= last_d;
         out_data_q <= out_data_d;
         out_addr_q <= out_addr_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
      end
   end

   // Status flags decode the state register only, never an input.
   assign out_valid = (state_q == ST_OUT);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign ram_addr  = ram_addr_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign checksum  = sum_q;
   assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_dm_dump_reader.sv
// Self-checking bench for dm_dump_reader: range table, named corner cases and
// randomized sweeps checked against a word-list model of the sweep.
module tb_dm_dump_reader;

   localparam int AW  = 6;
   localparam int DW  = 32;
   localparam int LAT = 1;

   logic          clk_sys = 1'b0;
   logic          rst, start, abort, out_ready;
   logic [AW-1:0] first_addr, last_addr, ram_addr, out_addr;
   logic [DW-1:0] memory, out_data, checksum;
   logic          out_valid, busy, done;
   logic [AW:0]   word_cnt;

   logic [DW-1:0] mem [64];
   int tests = 0;
   int fails = 0;

   always #5 clk_sys = ~clk_sys;

   // Synchronous-read DM model with one cycle of latency.
   always @(posedge clk_sys) memory <= mem[ram_addr];

   dm_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk_sys(clk_sys), .rst(rst), .start(start), .abort(abort),
      .first_addr(first_addr), .last_addr(last_addr), .ram_addr(ram_addr),
      .memory(memory), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done),
      .checksum(checksum), .word_cnt(word_cnt)
   );

   typedef struct {
      logic [AW-1:0] first;
      logic [AW-1:0] last;
      logic [DW-1:0] fill;
      int            exp_cnt;
      logic [DW-1:0] exp_sum;
   } vec_t;

   typedef struct {
      int            n_words;
      int            n_done;
      int            first_valid;
      int            last_hs;
      int            done_cyc;
      int            idle_cyc;
      logic [DW-1:0] sum;
   } sweep_res_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one sweep. Cycle index 0 is the sample just after the start edge; a
   // handshake is recorded at the sample where valid and ready are both presented.
   task automatic run_sweep(input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int stall_word, input int stall_len, input int abort_word,
                            input bit rand_ready, input bit redundant_start,
                            output sweep_res_t r);
      logic [AW-1:0] q[$];
      logic [AW-1:0] a, h_addr, h_ram;
      logic [DW-1:0] h_data;
      int  cyc, stall_left;
      bit  prev_stall, prev_abort, rdy, ab;

      a = f;
      forever begin
         q.push_back(a);
         if (a == l) break;
         a = a + AW'(1);
      end

      r = '{default: 0};
      r.first_valid = -1; r.last_hs = -1; r.done_cyc = -1; r.idle_cyc = -1;
      stall_left = stall_len; prev_stall = 0; prev_abort = 0;
      h_addr = '0; h_ram = '0; h_data = '0;

      @(negedge clk_sys);
      first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b0; abort = 1'b0;
      @(negedge clk_sys);
      cyc = 0;
      if (redundant_start) begin
         first_addr = f + AW'(13);
         last_addr  = f + AW'(20);
      end else begin
         start = 1'b0;
      end
      check("busy_after_start", busy, 1);
      check("ram_addr_after_start", ram_addr, f);

      forever begin
         if (prev_abort) begin
            check("abort_busy", busy, 0);
            check("abort_valid", out_valid, 0);
            check("abort_done", done, 0);
            r.idle_cyc = cyc;
            break;
         end
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, h_data);
            check("stall_addr", out_addr, h_addr);
            check("stall_ram_addr", ram_addr, h_ram);
         end
         if (done) begin
            r.n_done++;
            r.done_cyc = cyc;
         end
         if (out_valid && r.first_valid < 0) r.first_valid = cyc;
         if (!busy) begin
            r.idle_cyc = cyc;
            break;
         end
         if (cyc > 1000) begin
            check("sweep_timeout", cyc, 0);
            break;
         end

         ab = out_valid && (r.n_words == abort_word);
         if (ab) rdy = 1'b1;
         else if (out_valid && r.n_words == stall_word && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end
         else if (rand_ready) rdy = 1'($urandom_range(0, 1));
         else rdy = 1'b1;
         out_ready = rdy;
         abort     = ab;

         prev_stall = out_valid && !rdy && !ab;
         h_data = out_data; h_addr = out_addr; h_ram = ram_addr;
         if (out_valid && rdy && !ab) begin
            if (q.size() == 0) begin
               check("extra_word", 1, 0);
            end else begin
               check("word_addr", out_addr, q[0]);
               check("word_data", out_data, mem[q[0]]);
               r.sum = r.sum + mem[q[0]];
               void'(q.pop_front());
            end
            r.n_words++;
            r.last_hs = cyc;
         end
         prev_abort = ab;
         @(negedge clk_sys);
         cyc++;
      end
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      if (abort_word < 0) check("words_missing", q.size(), 0);
   endtask

   task automatic check_done_timing(input string tag, input sweep_res_t r);
      check({tag, "_done_pulses"}, r.n_done, 1);
      check({tag, "_done_cycle"}, r.done_cyc, r.last_hs + 1);
      check({tag, "_idle_cycle"}, r.idle_cyc, r.last_hs + 2);
   endtask

   initial begin
      vec_t          vecs [7];
      sweep_res_t    r, r0;
      logic [DW-1:0] cs0;
      logic [AW-1:0] f, l;

      vecs[0] = '{6'd3,  6'd5,  32'h0000_0022, 3,  32'h0000_0066};
      vecs[1] = '{6'd62, 6'd1,  32'hFFFF_FFFF, 4,  32'hFFFF_FFFC};
      vecs[2] = '{6'd7,  6'd7,  32'h0000_ABCD, 1,  32'h0000_ABCD};
      vecs[3] = '{6'd1,  6'd0,  32'h0000_0001, 64, 32'h0000_0040};
      vecs[4] = '{6'd0,  6'd63, 32'h1000_0000, 64, 32'h0000_0000};
      vecs[5] = '{6'd40, 6'd39, 32'h0000_0003, 64, 32'h0000_00C0};
      vecs[6] = '{6'd63, 6'd0,  32'h0000_0005, 2,  32'h0000_000A};

      for (int i = 0; i < 64; i++) mem[i] = '0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      first_addr = '0; last_addr = '0;
      repeat (3) @(negedge clk_sys);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_checksum", checksum, 0);
      check("rst_word_cnt", word_cnt, 0);
      rst = 1'b0;

      // Range rules from the table with a uniform memory fill.
      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < 64; i++) mem[i] = vecs[v].fill;
         run_sweep(vecs[v].first, vecs[v].last, -1, 0, -1, 1'b0, 1'b0, r);
         check($sformatf("vec%0d_words", v), r.n_words, vecs[v].exp_cnt);
         check($sformatf("vec%0d_word_cnt", v), word_cnt, vecs[v].exp_cnt);
         check($sformatf("vec%0d_checksum", v), checksum, vecs[v].exp_sum);
         check_done_timing($sformatf("vec%0d", v), r);
      end

      // Basic sweep with start-to-valid latency and per-word cadence.
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[3] = 32'h11; mem[4] = 32'h22; mem[5] = 32'h33;
      run_sweep(6'd3, 6'd5, -1, 0, -1, 1'b0, 1'b0, r);
      check("basic_first_valid", r.first_valid, 1 + LAT);
      check("basic_last_hs", r.last_hs, (1 + LAT) + 2 * (LAT + 2));
      check("basic_checksum", checksum, 32'h66);
      check("basic_word_cnt", word_cnt, 3);
      check_done_timing("basic", r);

      // Reset in ISSUE of word 2 with start high in the same cycle.
      @(negedge clk_sys);
      first_addr = 6'd3; last_addr = 6'd5; start = 1'b1; out_ready = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_valid", out_valid, 0);
      check("pre_rst_checksum", checksum, 32'h11);
      rst = 1'b1; start = 1'b1;
      @(negedge clk_sys);
      check("mid_rst_ram_addr", ram_addr, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_addr", out_addr, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_checksum", checksum, 0);
      check("mid_rst_word_cnt", word_cnt, 0);
      rst = 1'b0; start = 1'b0; out_ready = 1'b0;

      // Backpressure on word 2 must not change the stream or the checksum.
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      run_sweep(6'd20, 6'd25, -1, 0, -1, 1'b0, 1'b0, r0);
      cs0 = checksum;
      run_sweep(6'd20, 6'd25, 1, 5, -1, 1'b0, 1'b0, r);
      check("stall_checksum_vs_unstalled", checksum, cs0);
      check("stall_checksum_model", checksum, r.sum);
      check("stall_words", r.n_words, 6);
      check("stall_word_cnt", word_cnt, 6);
      check_done_timing("stall", r);

      // Abort coinciding with the handshake of the fifth word.
      run_sweep(6'd0, 6'd9, -1, 0, 4, 1'b0, 1'b0, r);
      check("abort_word_cnt", word_cnt, 4);
      check("abort_checksum", checksum, r.sum);
      check("abort_no_done", r.n_done, 0);

      // Single word with start held high for the whole sweep.
      run_sweep(6'd7, 6'd7, -1, 0, -1, 1'b0, 1'b1, r);
      check("single_words", r.n_words, 1);
      check("single_word_cnt", word_cnt, 1);
      check("single_checksum", checksum, mem[7]);
      check_done_timing("single", r);
      @(negedge clk_sys);
      check("single_no_restart", busy, 0);

      // Randomized ranges, data and backpressure.
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 64; i++) mem[i] = $urandom;
         f = AW'($urandom_range(0, 63));
         l = f + AW'($urandom_range(0, 12));
         run_sweep(f, l, -1, 0, -1, 1'b1, 1'b0, r);
         check($sformatf("rand%0d_words", k), r.n_words, int'(AW'(l - f)) + 1);
         check($sformatf("rand%0d_word_cnt", k), word_cnt, int'(AW'(l - f)) + 1);
         check($sformatf("rand%0d_checksum", k), checksum, r.sum);
         check($sformatf("rand%0d_done", k), r.n_done, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
